// File: rtl/psx_poller.sv
// psx_poller: console-side master for the PSX pad serial bus.
// On a start request it selects the pad (att low), clocks out the 5-byte
// digital poll 0x01 0x42 0x00 0x00 0x00 LSB first, and samples the pad's
// reply. After each of bytes 0-3 it waits for the pad's ack. When the poll
// succeeds it returns the 16-bit active-low button word.
//
// Parameters:
//   HALF_PER    clk cycles per psx_clk half period (>= 2)
//   ATT_SETUP   cycles from att low to the first psx_clk fall
//   ACK_TIMEOUT max cycles spent waiting for ack after bytes 0-3
//   BYTE_GAP    cycles from ack detection to the next byte's first fall
//   ATT_HOLD    cycles from the last rising edge to att release
//
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   start    single-cycle poll request, ignored while busy
//   data     pad -> console serial data (open-drain, idle high)
//   ack      pad acknowledge (active low, open-drain)
//   psx_clk  bus clock, idles high
//   cmd      console -> pad serial data, idles high
//   att      pad select, active low
//   busy     high from start acceptance until att is released
//   valid    one-cycle pulse on a successful poll
//   buttons  {byte4, byte3} of the last successful poll
//   pad_id   response byte 1 of the last completed or aborted poll
//   err      0 ok, 1 ack timeout, 2 bad ID / 0x5A marker
module psx_poller #(
  parameter int HALF_PER    = 4,
  parameter int ATT_SETUP   = 8,
  parameter int ACK_TIMEOUT = 32,
  parameter int BYTE_GAP    = 4,
  parameter int ATT_HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data,
  input  logic        ack,
  output logic        psx_clk,
  output logic        cmd,
  output logic        att,
  output logic        busy,
  output logic        valid,
  output logic [15:0] buttons,
  output logic [7:0]  pad_id,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BIT_LO,
    S_BIT_HI,
    S_WAIT_ACK,
    S_GAP,
    S_HOLD
  } state_t;

  // Terminal counts: each phase ends on the cycle where cnt hits its last value.
  localparam logic [7:0] LAST_HALF  = 8'(HALF_PER - 1);
  localparam logic [7:0] LAST_SETUP = 8'(ATT_SETUP - 1);
  localparam logic [7:0] LAST_ACK   = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] LAST_GAP   = 8'(BYTE_GAP - 1);
  localparam logic [7:0] LAST_HOLD  = 8'(ATT_HOLD - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [7:0]  rx;
  logic [7:0]  rx_next;
  logic [7:0]  id_byte;
  logic [7:0]  byte3;
  logic [7:0]  byte4;
  logic        got_id;
  logic [1:0]  abort_code;
  logic [7:0]  cmd_byte;
  logic        data_s1;
  logic        data_s2;
  logic        ack_s1;
  logic        ack_s2;

  // Two-flop synchronizers for the open-drain pad lines. They reset to the
  // idle-high level, so a reset never looks like an ack or a zero data bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      ack_s1  <= 1'b1;
      ack_s2  <= 1'b1;
    end else begin
      data_s1 <= data;
      data_s2 <= data_s1;
      ack_s1  <= ack;
      ack_s2  <= ack_s1;
    end
  end

  // Command byte for the byte currently on the bus.
  always_comb begin
    cmd_byte = 8'h00;
    case (byte_idx)
      3'd0:    cmd_byte = 8'h01;
      3'd1:    cmd_byte = 8'h42;
      default: cmd_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. rx_next is the byte as it will look after the current
  // sample is shifted in, so the ID/marker check after byte 2 can be decided
  // on the same cycle the last bit arrives.
  always_comb begin
    next_state = state;
    abort_code = 2'd0;
    rx_next    = {data_s2, rx[7:1]};
    case (state)
      S_IDLE:
        if (start) next_state = S_SETUP;
      S_SETUP:
        if (cnt == LAST_SETUP) next_state = S_BIT_LO;
      S_BIT_LO:
        if (cnt == LAST_HALF) next_state = S_BIT_HI;
      S_BIT_HI:
        if (cnt == LAST_HALF) begin
          if (bit_idx != 3'd7) begin
            next_state = S_BIT_LO;
          end else if (byte_idx == 3'd4) begin
            next_state = S_HOLD;
          end else if (byte_idx == 3'd2 && (id_byte != 8'h41 || rx_next != 8'h5A)) begin
            next_state = S_HOLD;
            abort_code = 2'd2;
          end else begin
            next_state = S_WAIT_ACK;
          end
        end
      S_WAIT_ACK:
        if (!ack_s2) begin
          next_state = S_GAP;
        end else if (cnt == LAST_ACK) begin
          next_state = S_HOLD;
          abort_code = 2'd1;
        end
      S_GAP:
        if (cnt == LAST_GAP) next_state = S_BIT_LO;
      S_HOLD:
        if (cnt == LAST_HOLD) next_state = S_IDLE;
      default:
        next_state = S_IDLE;
    endcase
  end

  // Bus outputs follow the state directly. cmd holds its bit through the
  // high phase, so it only moves on falling-edge cycles or phase exits.
  always_comb begin
    att     = (state == S_IDLE);
    busy    = (state != S_IDLE);
    psx_clk = (state != S_BIT_LO);
    cmd     = 1'b1;
    if (state == S_BIT_LO || state == S_BIT_HI) cmd = cmd_byte[bit_idx];
  end

  // Datapath: the phase counter restarts on every state change; receive
  // bytes are captured as they complete, and results are published on the
  // last HOLD cycle so valid, buttons and pad_id change together with att.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 3'd0;
      rx       <= 8'd0;
      id_byte  <= 8'd0;
      byte3    <= 8'd0;
      byte4    <= 8'd0;
      got_id   <= 1'b0;
      valid    <= 1'b0;
      buttons  <= 16'hFFFF;
      pad_id   <= 8'h00;
      err      <= 2'd0;
    end else begin
      valid <= 1'b0;
      cnt   <= (next_state != state) ? 8'd0 : cnt + 8'd1;
      case (state)
        S_IDLE:
          if (start) begin
            err      <= 2'd0;
            got_id   <= 1'b0;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
          end
        S_BIT_HI:
          if (cnt == LAST_HALF) begin
            rx      <= rx_next;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              case (byte_idx)
                3'd1: begin
                  id_byte <= rx_next;
                  got_id  <= 1'b1;
                end
                3'd3:    byte3 <= rx_next;
                3'd4:    byte4 <= rx_next;
                default: ;
              endcase
            end
          end
        S_GAP:
          if (cnt == LAST_GAP) byte_idx <= byte_idx + 3'd1;
        S_HOLD:
          if (cnt == LAST_HOLD) begin
            if (err == 2'd0) begin
              buttons <= {byte4, byte3};
              pad_id  <= id_byte;
              valid   <= 1'b1;
            end else if (got_id) begin
              pad_id  <= id_byte;
            end
          end
        default: ;
      endcase
      if (abort_code != 2'd0) err <= abort_code;
    end
  end

endmodule

// File: tb/tb_psx_poller.sv
// tb_psx_poller: self-checking bench for psx_poller.
// A cycle-stepped pad model answers on the bus with configurable response
// bytes and ack behaviour, and records the command bits and psx_clk phase
// lengths it sees. A result model derives err/buttons/pad_id/valid from the
// configured pad behaviour and the poll rules.
module tb_psx_poller;

  localparam int HP      = 4;
  localparam int SETUP   = 8;
  localparam int TIMEOUT = 32;
  localparam int GAP     = 4;
  localparam int HOLD    = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        data;
  logic        ack;
  logic        psx_clk;
  logic        cmd;
  logic        att;
  logic        busy;
  logic        valid;
  logic [15:0] buttons;
  logic [7:0]  pad_id;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  // Pad configuration for the next poll.
  logic [7:0] resp [5];
  bit         ack_en [4];
  int         ack_dly;

  // Pad observations.
  logic [7:0] cmd_rx [5];
  int         bytes_seen;
  int         bad_half;
  int         pad_byte;

  // Result model state carried between polls.
  logic [15:0] mdl_buttons = 16'hFFFF;
  logic [7:0]  mdl_id      = 8'h00;

  // Per-poll measurements.
  int busy_len;
  int n_trans;
  int valid_cnt;
  bit done;

  psx_poller #(
    .HALF_PER(HP), .ATT_SETUP(SETUP), .ACK_TIMEOUT(TIMEOUT),
    .BYTE_GAP(GAP), .ATT_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .ack(ack),
    .psx_clk(psx_clk), .cmd(cmd), .att(att), .busy(busy), .valid(valid),
    .buttons(buttons), .pad_id(pad_id), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model, stepped on every falling clk edge. It drives data on psx_clk
  // falls, captures cmd on rises, checks half-period lengths, and pulls ack
  // low for 3 cycles ack_dly cycles after each enabled byte ends.
  initial begin : pad_model
    int   bit_cnt;
    int   run_len;
    int   ack_wait;
    int   ack_low;
    logic prev_clk;
    bit_cnt = 0; run_len = 0; ack_wait = -1; ack_low = 0; prev_clk = 1'b1;
    pad_byte = 0;
    data = 1'b1;
    ack  = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n || att) begin
        pad_byte = 0; bit_cnt = 0; run_len = 0; ack_wait = -1; ack_low = 0;
        data = 1'b1; ack = 1'b1; prev_clk = 1'b1;
      end else begin
        run_len++;
        if (prev_clk && !psx_clk) begin
          if (bit_cnt != 0 && run_len != HP) bad_half++;
          run_len = 0;
          if (pad_byte < 5) data = resp[pad_byte][bit_cnt];
        end else if (!prev_clk && psx_clk) begin
          if (run_len != HP) bad_half++;
          run_len = 0;
          if (pad_byte < 5) cmd_rx[pad_byte][bit_cnt] = cmd;
          if (bit_cnt == 7) begin
            bit_cnt = 0;
            bytes_seen++;
            if (pad_byte < 4 && ack_en[pad_byte]) ack_wait = ack_dly;
            pad_byte++;
          end else begin
            bit_cnt++;
          end
        end
        if (ack_low > 0) begin
          ack_low--;
          if (ack_low == 0) ack = 1'b1;
        end
        if (ack_wait == 0) begin
          ack = 1'b0; ack_low = 3; ack_wait = -1;
        end else if (ack_wait > 0) begin
          ack_wait--;
        end
        prev_clk = psx_clk;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result model: walks the poll's abort points in order and decides the
  // error code, how many bytes reach the bus, and the published results.
  task automatic modelPoll(output logic [1:0] e, output int v, output int nb);
    v = 0;
    if (!ack_en[0]) begin
      e = 2'd1; nb = 1;
    end else begin
      mdl_id = resp[1];
      if (!ack_en[1]) begin
        e = 2'd1; nb = 2;
      end else if (resp[1] != 8'h41 || resp[2] != 8'h5A) begin
        e = 2'd2; nb = 3;
      end else if (!ack_en[2]) begin
        e = 2'd1; nb = 3;
      end else if (!ack_en[3]) begin
        e = 2'd1; nb = 4;
      end else begin
        e = 2'd0; nb = 5; v = 1;
        mdl_buttons = {resp[4], resp[3]};
      end
    end
  endtask

  // Issue one start pulse and follow the transaction until busy drops,
  // optionally re-pulsing start while byte 1 is on the bus.
  task automatic applyStimulus(input bit extra_start);
    bit prev_busy;
    bit extra_done;
    bytes_seen = 0; bad_half = 0; valid_cnt = 0; extra_done = 1'b0;
    for (int i = 0; i < 5; i++) cmd_rx[i] = 8'hXX;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    busy_len  = busy ? 1 : 0;
    n_trans   = busy ? 1 : 0;
    prev_busy = busy;
    done      = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (extra_start && !extra_done && pad_byte == 1) begin
        start = 1'b1; extra_done = 1'b1;
      end
      if (valid) valid_cnt++;
      if (busy && !prev_busy) n_trans++;
      if (busy) busy_len++;
      else done = 1'b1;
      prev_busy = busy;
    end
    start = 1'b0;
    checkOutput("poll_done", 32'(done), 32'd1);
  endtask

  // Run one poll with the current pad configuration and check everything
  // the model can predict.
  task automatic runPoll(input string name, input bit extra_start);
    logic [1:0] e;
    int         v;
    int         nb;
    logic [7:0] exp_cmd [5];
    exp_cmd[0] = 8'h01; exp_cmd[1] = 8'h42;
    exp_cmd[2] = 8'h00; exp_cmd[3] = 8'h00; exp_cmd[4] = 8'h00;
    modelPoll(e, v, nb);
    applyStimulus(extra_start);
    $display("[TB] %s: err=%0d buttons=%h pad_id=%h", name, err, buttons, pad_id);
    checkOutput({name, "_err"}, 32'(err), 32'(e));
    checkOutput({name, "_buttons"}, 32'(buttons), 32'(mdl_buttons));
    checkOutput({name, "_pad_id"}, 32'(pad_id), 32'(mdl_id));
    checkOutput({name, "_valid_cnt"}, 32'(valid_cnt), 32'(v));
    checkOutput({name, "_transactions"}, 32'(n_trans), 32'd1);
    checkOutput({name, "_bytes"}, 32'(bytes_seen), 32'(nb));
    checkOutput({name, "_half_period"}, 32'(bad_half), 32'd0);
    for (int i = 0; i < nb; i++)
      checkOutput($sformatf("%s_cmd%0d", name, i), 32'(cmd_rx[i]), 32'(exp_cmd[i]));
    if (!ack_en[0])
      checkOutput({name, "_busy_len"}, 32'(busy_len), 32'(SETUP + 16 * HP + TIMEOUT + HOLD));
  endtask

  task automatic setNominal();
    resp[0] = 8'hFF; resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'hFE; resp[4] = 8'h7F;
    for (int i = 0; i < 4; i++) ack_en[i] = 1'b1;
    ack_dly = 6;
  endtask

  initial begin : main
    int         kind;
    logic [7:0] x;
    int         guard;
    rst_n = 1'b0;
    start = 1'b0;
    setNominal();

    // Reset values after 3 cycles of reset.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_att", 32'(att), 32'd1);
    checkOutput("rst_psx_clk", 32'(psx_clk), 32'd1);
    checkOutput("rst_cmd", 32'(cmd), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_buttons", 32'(buttons), 32'hFFFF);
    checkOutput("rst_pad_id", 32'(pad_id), 32'h00);
    checkOutput("rst_err", 32'(err), 32'd0);

    // Nominal poll.
    setNominal();
    runPoll("nominal", 1'b0);
    checkOutput("nominal_buttons_const", 32'(buttons), 32'h7FFE);

    // Ack timeout on byte 0.
    setNominal();
    ack_en[0] = 1'b0;
    runPoll("timeout0", 1'b0);

    // Bad pad ID.
    setNominal();
    resp[1] = 8'h73;
    runPoll("bad_id", 1'b0);
    checkOutput("bad_id_pad_id_const", 32'(pad_id), 32'h73);

    // Start while busy: still exactly one transaction.
    setNominal();
    resp[3] = 8'($urandom_range(0, 255));
    resp[4] = 8'($urandom_range(0, 255));
    runPoll("start_busy", 1'b1);

    // Randomized polls.
    for (int n = 0; n < 6; n++) begin
      setNominal();
      resp[0] = 8'($urandom_range(0, 255));
      resp[3] = 8'($urandom_range(0, 255));
      resp[4] = 8'($urandom_range(0, 255));
      ack_dly = $urandom_range(5, 12);
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        ack_en[$urandom_range(0, 3)] = 1'b0;
      end else if (kind == 2) begin
        x = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) begin
          if (x == 8'h41) x = 8'h40;
          resp[1] = x;
        end else begin
          if (x == 8'h5A) x = 8'h5B;
          resp[2] = x;
        end
      end
      runPoll($sformatf("rand%0d", n), kind == 3);
    end

    // Reset in the middle of byte 3.
    setNominal();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (pad_byte != 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("midrst_reached_byte3", 32'(pad_byte), 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_att", 32'(att), 32'd1);
    checkOutput("midrst_psx_clk", 32'(psx_clk), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(valid), 32'd0);
    checkOutput("midrst_buttons", 32'(buttons), 32'hFFFF);
    rst_n = 1'b1;
    mdl_buttons = 16'hFFFF;
    mdl_id      = 8'h00;

    // Recovery poll after the mid-transaction reset.
    setNominal();
    resp[3] = 8'($urandom_range(0, 255));
    runPoll("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psx_poller.md
# psx_poller

Console-side master for the PSX pad serial bus: on request it drives `att`, `psx_clk` and `cmd` through the standard 5-byte digital poll (0x01 0x42 0x00 0x00 0x00). It samples `data`, waits for `ack` after each byte and returns the 16-bit button word. It is the sequencer that exercises `fake_controller` in-system and replaces the captured-trace stimulus used in bench work.

## Interface
- `HALF_PER`, 4, `clk` cycles per `psx_clk` half period (≥2)
- `ATT_SETUP`, 8, cycles from `att` low to first `psx_clk` fall
- `ACK_TIMEOUT`, 32, max cycles waiting for `ack` after bytes 0–3
- `BYTE_GAP`, 4, cycles from ack detection to next byte's first fall
- `ATT_HOLD`, 4, cycles from last rising edge to `att` release
- `clk  in  1  system clock`
- `rst_n  in  1  synchronous active-low reset`
- `start  in  1  single-cycle poll request; ignored while busy`
- `data  in  1  pad → console serial data, open-drain, idle high`
- `ack  in  1  pad acknowledge, active low, open-drain`
- `psx_clk  out  1  bus clock, idles high`
- `cmd  out  1  console → pad serial data, idles high`
- `att  out  1  pad select, active low`
- `busy  out  1  high from start acceptance until `att` released`
- `valid  out  1  one-cycle pulse on a successful poll`
- `buttons  out  16  {byte4, byte3}, active-low button bits`
- `pad_id  out  8  response byte 1 of last completed or aborted poll`
- `err  out  2  0 ok, 1 ack timeout, 2 bad ID/0x5A marker`

## Operation
- `data` and `ack` pass through 2-flop synchronizers; all decisions use synchronized values.
- States: IDLE → SETUP → BIT_LO → BIT_HI → (WAIT_ACK → GAP → BIT_LO)… → HOLD → IDLE.
- IDLE: `att`=1, `psx_clk`=1, `cmd`=1. `start`=1 moves to SETUP, drops `att`, sets `busy`, and clears `err` at the same edge.
- SETUP: lasts ATT_SETUP cycles, then enters BIT_LO with byte index 0 and bit 0.
- BIT_LO: `psx_clk`=0 and `cmd`=current bit, LSB first, for HALF_PER cycles.
- BIT_HI: `psx_clk`=1 for HALF_PER cycles. The synchronized `data` is shifted into the receive byte (LSB first) on the last cycle of the phase.
- After bit 7 of bytes 0–3: enter WAIT_ACK with `psx_clk`=1 and `cmd`=1.
  - If the synchronized `ack` is low within ACK_TIMEOUT cycles, go to GAP.
  - Otherwise go to HOLD with `err`=1.
- After byte 2 completes, check the receive bytes. If byte 1 ≠ 0x41 or byte 2 ≠ 0x5A, skip WAIT_ACK and go to HOLD with `err`=2.
- After byte 4, go directly to HOLD; no ack is expected.
- GAP: lasts BYTE_GAP cycles, then the next byte starts in BIT_LO.
- HOLD: lasts ATT_HOLD cycles, then `att`=1, `busy`=0, return to IDLE.
  - If `err`=0, `buttons` and `pad_id` update and `valid` pulses on the same cycle.
  - If aborted, `pad_id` updates when byte 1 was received; `buttons` holds its old value.
- `start` while busy is ignored and not queued.

## Timing
- Reset values: `att`=1, `psx_clk`=1, `cmd`=1, `busy`=0, `valid`=0, `buttons`=16'hFFFF, `pad_id`=8'h00, `err`=0. FSM and synchronizers are cleared.
- Reset asserted mid-transaction takes effect at the next edge; the bus returns to idle with no `valid`.
- Measured from the `start` sampling edge:
  - `att` falls 1 cycle later.
  - First `psx_clk` fall is ATT_SETUP cycles after that.
  - One byte lasts 16·HALF_PER cycles.
- `cmd` changes only on `psx_clk` falling-edge cycles (or on entry to WAIT_ACK, IDLE or HOLD). This gives it HALF_PER cycles of setup before the rising edge.
- Ack latency: detection occurs 2–3 cycles after the raw `ack` falls. An `ack` pulse must stay low ≥2 cycles to be seen.
- `ack` pulses seen outside WAIT_ACK are ignored.
- Successful poll length: 1 + ATT_SETUP + 5·16·HALF_PER + 4·(ack wait + BYTE_GAP) + ATT_HOLD cycles.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs at their listed reset values; `start` is honored on the next cycle.
- **Nominal poll:** pad model answers 0xFF,0x41,0x5A,0xFE,0x7F and acks 6 cycles after each of bytes 0–3.
  - Bus: `cmd` carries 01,42,00,00,00 LSB first; `psx_clk` half periods are exactly 4 cycles.
  - Result: `buttons`=16'h7FFE, `pad_id`=0x41, `err`=0, single `valid` pulse.
- **Ack timeout:** pad never acks byte 0 → `att` rises ATT_HOLD cycles after the 32-cycle timeout; `err`=1; `buttons` keep their previous value; no `valid`.
- **Bad ID:** pad answers byte 1 = 0x73 → abort after byte 2; `err`=2, `pad_id`=0x73, `buttons` unchanged; no `valid`.
- **Start while busy:** pulse `start` during byte 1 → exactly one transaction occurs (5 bytes, one `valid`).
- **Reset mid-transaction:** assert `rst_n`=0 mid byte 3 → next cycle `att`=1, `psx_clk`=1, `busy`=0, `buttons`=16'hFFFF.
